fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Producer side of the fetch/decode pipeline boundary.
- Owns the PC and runs read transactions on the instruction-memory bus (read/waitrequest handshake).
- Presents instruction_fetch and PC_plus_four_fetch, registered, to the fetch/decode pipeline register.
- Has a one-entry skid buffer so a word returned during a downstream stall is not lost. Handles branch/jump redirects, including a redirect that arrives while a read is still in flight.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
stall_fetch  in  1  active-high stall from hazard unit; 1 = hold outputs
branch_taken  in  1  single-cycle redirect request
branch_target  in  32  redirect PC, valid with branch_taken
imem_address  out  32  read address, equal to PC while imem_read=1
imem_read  out  1  read request
imem_waitrequest  in  1  1 = request not accepted this cycle
imem_readdata  in  32  read data, valid in the accept cycle
instruction_fetch  out  32  fetched instruction to pipeline register
PC_plus_four_fetch  out  32  address of that instruction + 4
fetch_valid  out  1  1 = outputs hold a real instruction, 0 = bubble (NOP)

Behaviour:
- Reset (async, immediate) sets:
  - PC=RESET_VECTOR; instruction_fetch=0; PC_plus_four_fetch=0; fetch_valid=0
  - buffer empty; state=REQ; imem_read=0 while reset is high
- First request is issued in the first cycle after reset deasserts.
- Definitions:
  - accept = imem_read & !imem_waitrequest
  - advance = !stall_fetch
- FSM states:
  - REQ: imem_read=1, imem_address=PC. Address must stay stable until accept.
  - DISCARD: same bus signals as REQ; the returned word is dropped.
  - IDLE: imem_read=0.
- Transitions:
  - REQ, accept, kept word lands in buffer (stall_fetch=1) -> IDLE; otherwise REQ.
  - REQ, branch_taken with no accept, or with accept in the same cycle:
    - no accept -> DISCARD
    - accept -> REQ; word dropped.
  - DISCARD, accept -> REQ (word dropped, PC already redirected).
  - IDLE, buffer drained by advance -> REQ.
- An issued request is never withdrawn: it stays asserted through stall_fetch and branch_taken until accept.
- PC update priority:
  1. branch_taken: PC<=branch_target
  2. kept accept: PC<=PC+4 (32-bit wrap, 32'hFFFFFFFC -> 0)
  3. else hold
- Kept accept handling:
  - advance=1: output register loads {imem_readdata, PC+4}, fetch_valid<=1. Latency from accept = 1 cycle.
  - advance=0: word and PC+4 are written to the skid buffer.
- Output register, when advance=1, loads in priority order:
  1. buffer contents (buffer then empties)
  2. kept accept
  3. otherwise a bubble: instruction_fetch<=0, PC_plus_four_fetch<=0, fetch_valid<=0
- stall_fetch=1: the output register holds all three outputs unchanged.
- Buffer-full case: no new request is issued while the buffer is full, so at most one word is pending.
- branch_taken effects:
  - Invalidates the buffer.
  - Does not alter the current output register; the delay-slot instruction already presented stays, and downstream clear handles squashing.
  - With stall_fetch=1, the redirect still takes effect immediately.
  - A second branch_taken while in DISCARD retargets the PC; the in-flight word is still dropped.
- Reset mid-transaction: the bus drops imem_read asynchronously. The memory subsystem is reset by the same signal.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output port fetch_address_error (1 bit, reset 0).
  - If a PC with bits[1:0]!=0 would be fetched, no request is issued.
  - fetch_address_error<=1 (sticky until reset); state goes to IDLE permanently; outputs carry bubbles.
- Not defined:
  - No port.
  - branch_target[1:0] is ignored (PC<=target & 32'hFFFFFFFC).

Test Plan:
- Reset release, waitrequest=0, memory[BFC00000]=32'h24080001 -> imem_address=BFC00000 in cycle 1; next cycle instruction_fetch=24080001, PC_plus_four_fetch=BFC00004, fetch_valid=1.
- waitrequest=1 for 3 cycles -> imem_read and imem_address=BFC00000 held stable 4 cycles; fetch_valid=0 until the cycle after accept.
- stall_fetch=1 at accept of word at BFC00004 -> outputs unchanged; word buffered; imem_read=0; stall drops -> outputs show the buffered word with PC_plus_four_fetch=BFC00008, then the read of BFC00008 is issued.
- branch_taken with target 80000100 while the read of BFC00008 is waiting -> read held until accept, data dropped (fetch_valid=0); next request address=80000100.
- branch_taken in the same cycle as an accept -> that word is never presented; PC=target; no PC+4 increment.
- FETCH_ALIGN_CHECK_EN defined, branch_target=80000102 -> fetch_address_error=1, imem_read stays 0, fetch_valid=0 until reset.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, imem read master, one-entry skid buffer.
// Define FETCH_ALIGN_CHECK_EN to add fetch_address_error and misaligned-PC trap.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_fetch,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic [31:0] imem_readdata,
  output logic [31:0] instruction_fetch,
  output logic [31:0] PC_plus_four_fetch,
  output logic        fetch_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_address_error
`endif
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    DISCARD = 2'd1,
    IDLE    = 2'd2
  } state_t;

  state_t state, state_raw, state_n;

  logic [31:0] pc, pc_n, pc_plus4, tgt, addr;
  logic [31:0] skid_instr, skid_pc4;
  logic        skid_valid;
  logic        accept, advance, kept;

  assign accept   = imem_read & ~imem_waitrequest;
  assign advance  = ~stall_fetch;
  assign kept     = accept & (state == REQ) & ~branch_taken;
  assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt = branch_target;
`else
  assign tgt = branch_target & 32'hFFFFFFFC;
`endif

  always_comb begin
    pc_n = pc;
    if (branch_taken)
      pc_n = tgt;
    else if (kept)
      pc_n = pc_plus4;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= REQ;
    else
      state <= state_n;
  end

  // next state
  always_comb begin
    state_raw = state;
    unique case (state)
      REQ: begin
        if (branch_taken)
          state_raw = accept ? REQ : DISCARD;
        else if (accept)
          state_raw = stall_fetch ? IDLE : REQ;
      end
      DISCARD: begin
        if (accept)
          state_raw = REQ;
      end
      IDLE: begin
        if (advance | branch_taken)
          state_raw = REQ;
      end
      default: state_raw = REQ;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic issue_bad;

  // a new request to a misaligned PC is never issued; the trap is sticky
  assign issue_bad = ((state_raw == REQ) & (pc_n[1:0] != 2'b00))
                   | fetch_address_error;
  assign state_n   = issue_bad ? IDLE : state_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fetch_address_error <= 1'b0;
    else if (issue_bad)
      fetch_address_error <= 1'b1;
  end
`else
  assign state_n = state_raw;
`endif

  // bus outputs; read drops immediately on reset
  always_comb begin
    imem_read    = ~reset & (state != IDLE);
    imem_address = addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc                 <= RESET_VECTOR;
      addr               <= RESET_VECTOR;
      skid_valid         <= 1'b0;
      skid_instr         <= '0;
      skid_pc4           <= '0;
      instruction_fetch  <= '0;
      PC_plus_four_fetch <= '0;
      fetch_valid        <= 1'b0;
    end else begin
      pc <= pc_n;
      // address latched only when a fresh request starts
      if (state_n == REQ)
        addr <= pc_n;

      if (branch_taken) begin
        skid_valid <= 1'b0;
      end else if (kept & stall_fetch) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_readdata;
        skid_pc4   <= pc_plus4;
      end else if (advance) begin
        skid_valid <= 1'b0;
      end

      if (advance) begin
        if (skid_valid & ~branch_taken) begin
          instruction_fetch  <= skid_instr;
          PC_plus_four_fetch <= skid_pc4;
          fetch_valid        <= 1'b1;
        end else if (kept) begin
          instruction_fetch  <= imem_readdata;
          PC_plus_four_fetch <= pc_plus4;
          fetch_valid        <= 1'b1;
        end else begin
          instruction_fetch  <= '0;
          PC_plus_four_fetch <= '0;
          fetch_valid        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random bus/stall/branch stimulus, queue model + scoreboard.
// Define FETCH_ALIGN_CHECK_EN to also exercise the misaligned-target trap.
module tb_fetch_stage;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_fetch;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_waitrequest;
  logic [31:0] imem_readdata;
  logic [31:0] instruction_fetch;
  logic [31:0] PC_plus_four_fetch;
  logic        fetch_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_address_error;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc4;
  } out_t;

  out_t        expq[$];
  out_t        pend[$];
  out_t        cur;
  logic [31:0] exp_pc;
  bit          wanted;
  bit          prev_pend;
  logic [31:0] prev_addr;
  bit          model_on = 1'b0;
  int          kept_cnt = 0;

  fetch_stage #(.RESET_VECTOR(RV)) dut (
    .clk(clk),
    .reset(reset),
    .stall_fetch(stall_fetch),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_address(imem_address),
    .imem_read(imem_read),
    .imem_waitrequest(imem_waitrequest),
    .imem_readdata(imem_readdata),
    .instruction_fetch(instruction_fetch),
    .PC_plus_four_fetch(PC_plus_four_fetch),
    .fetch_valid(fetch_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_address_error(fetch_address_error)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == RV)
      return 32'h24080001;
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  assign imem_readdata = mem(imem_address);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // reference model: program-order stream of wanted words, FIFO of unseen ones
  always @(negedge clk) begin
    bit acc, br, adv;
    if (model_on && !reset) begin
      acc = imem_read && !imem_waitrequest;
      br  = branch_taken;
      adv = !stall_fetch;
      chk("read_iff_no_pending", {31'd0, imem_read},
          {31'd0, pend.size() == 0});
      if (prev_pend) begin
        chk("req_held", {31'd0, imem_read}, 32'd1);
        chk("addr_held", imem_address, prev_addr);
      end
      prev_pend = imem_read && !acc;
      prev_addr = imem_address;
      if (acc && !br && wanted) begin
        chk("fetch_addr", imem_address, exp_pc);
        pend.push_back('{1'b1, mem(exp_pc), exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
        kept_cnt++;
      end
      if (br) begin
        wanted = acc || !imem_read;
        exp_pc = branch_target & 32'hFFFFFFFC;
        pend.delete();
      end else if (acc) begin
        wanted = 1'b1;
      end
      if (adv) begin
        if (pend.size() > 0)
          cur = pend.pop_front();
        else
          cur = '{1'b0, 32'd0, 32'd0};
      end
      expq.push_back(cur);
    end
  end

  // scoreboard monitor
  always @(posedge clk) begin
    out_t e;
    #1;
    if (model_on && expq.size() > 0) begin
      e = expq.pop_front();
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.v});
      chk("instruction_fetch", instruction_fetch, e.ins);
      chk("pc_plus_four", PC_plus_four_fetch, e.pc4);
    end
  end

  task automatic step(input bit st, input bit br,
                      input logic [31:0] tg, input bit wr);
    stall_fetch      = st;
    branch_taken     = br;
    branch_target    = tg;
    imem_waitrequest = wr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] tg;
    reset            = 1'b1;
    stall_fetch      = 1'b0;
    branch_taken     = 1'b0;
    branch_target    = 32'd0;
    imem_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read", {31'd0, imem_read}, 32'd0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_instr", instruction_fetch, 32'd0);
    chk("rst_pc4", PC_plus_four_fetch, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_err", {31'd0, fetch_address_error}, 32'd0);
`endif
    exp_pc    = RV;
    wanted    = 1'b1;
    prev_pend = 1'b0;
    cur       = '{1'b0, 32'd0, 32'd0};
    pend.delete();
    expq.delete();
    model_on  = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("first_addr", imem_address, RV);

    step(0, 0, 0, 0);
    chk("first_instr", instruction_fetch, 32'h24080001);
    chk("first_pc4", PC_plus_four_fetch, RV + 32'd4);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("stalled_idle", {31'd0, imem_read}, 32'd0);
    step(0, 0, 0, 1);
    chk("skid_pc4", PC_plus_four_fetch, RV + 32'd8);
    step(0, 0, 0, 1);
    step(0, 1, 32'h80000100, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("redirect_addr", imem_address, 32'h80000100);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 32'h00001000, 0);
    chk("br_accept_addr", imem_address, 32'h00001000);
    step(0, 1, 32'hFFFFFFF8, 0);
    repeat (3) step(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      tg = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      tg = tg & 32'hFFFFFFFC;
`endif
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8,
           tg, $urandom_range(0, 9) < 4);
    end
    step(0, 0, 0, 0);
    chk("progress", {31'd0, kept_cnt > 500}, 32'd1);

`ifdef FETCH_ALIGN_CHECK_EN
    model_on = 1'b0;
    step(0, 1, 32'h80000102, 0);
    repeat (4) begin
      step(0, 0, 0, 0);
      chk("align_err", {31'd0, fetch_address_error}, 32'd1);
      chk("align_read", {31'd0, imem_read}, 32'd0);
      chk("align_valid", {31'd0, fetch_valid}, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
